// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO family.
// Holds defaults, the read-mode encoding and the address-width helper.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DEPTH      = 16;

    typedef enum logic {
        FIFO_REG  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Ceiling log2 of depth; never returns less than 1 so a port width is always legal.
    function automatic int unsigned fifo_addr_w(input int unsigned depth);
        int unsigned w;
        w = 0;
        while (w < 31 && (32'd1 << w) < depth) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read.
// Written without reset so it maps onto distributed RAM.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    localparam int unsigned ADDR_WIDTH = fifo_addr_w(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO with fill count, programmable thresholds,
// overflow/underflow pulses, synchronous flush and registered or fall-through output.
module sync_fifo_gen
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned AFULL_TH   = 12,
    parameter int unsigned AEMPTY_TH  = 4,
    parameter int unsigned FWFT       = 0,
    localparam int unsigned ADDR_WIDTH = fifo_addr_w(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enb,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DepthCnt  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AfullCnt  = (ADDR_WIDTH + 1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AemptyCnt = (ADDR_WIDTH + 1)'(AEMPTY_TH);
    localparam bit UseFwft = (FWFT == int'(FIFO_FWFT));

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_gen: DEPTH must be a power of two >= 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_gen: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_gen: AEMPTY_TH must be in 0..DEPTH-1");
    end
    if (FWFT > 1) begin : g_bad_mode
        $error("sync_fifo_gen: FWFT must be 0 or 1");
    end

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    assign full         = (count_q == DepthCnt);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AfullCnt);
    assign almost_empty = (count_q <= AemptyCnt);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = write_enb & ~full & ~clear;
    assign rd_acc = read & ~empty & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= write_enb & full & ~clear;
            underflow_q <= read & empty & ~clear;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    if (UseFwft) begin : g_fwft
        // Head word is visible without a read; forced to zero so an empty FIFO shows no stale data.
        assign data_out = empty ? '0 : rd_data;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                dout_q <= '0;
            end else if (clear) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rd_data;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Self-checking bench for sync_fifo_gen: one registered-output and one fall-through instance,
// expected read data tracked in scoreboard queues.
module tb_sync_fifo_gen;

    logic       clock;
    logic       reset;

    logic       clear, write_enb, read;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_clear, f_write_enb, f_read;
    logic [7:0] f_data_in, f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         mcount  = 0;
    logic [7:0] sb_q[$];
    logic [7:0] fsb_q[$];
    logic [7:0] exp_v;

    sync_fifo_gen #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .AFULL_TH   (12),
        .AEMPTY_TH  (4),
        .FWFT       (0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clear        (clear),
        .data_in      (data_in),
        .write_enb    (write_enb),
        .read         (read),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    sync_fifo_gen #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .AFULL_TH   (12),
        .AEMPTY_TH  (4),
        .FWFT       (1)
    ) dut_f (
        .clock        (clock),
        .reset        (reset),
        .clear        (f_clear),
        .data_in      (f_data_in),
        .write_enb    (f_write_enb),
        .read         (f_read),
        .data_out     (f_data_out),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_almost_full),
        .almost_empty (f_almost_empty),
        .count        (f_count),
        .overflow     (f_overflow),
        .underflow    (f_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_count"}, count, 0);
        check_eq({tag, "_empty"}, empty, 1);
        check_eq({tag, "_full"}, full, 0);
        check_eq({tag, "_aempty"}, almost_empty, 1);
        check_eq({tag, "_afull"}, almost_full, 0);
        check_eq({tag, "_dout"}, data_out, 0);
        check_eq({tag, "_ovf"}, overflow, 0);
        check_eq({tag, "_udf"}, underflow, 0);
        check_eq({tag, "_f_count"}, f_count, 0);
        check_eq({tag, "_f_empty"}, f_empty, 1);
        check_eq({tag, "_f_dout"}, f_data_out, 0);
        check_eq({tag, "_f_ovf"}, f_overflow, 0);
        check_eq({tag, "_f_udf"}, f_underflow, 0);
    endtask

    initial begin
        reset = 1'b1;
        clear = 0; write_enb = 0; read = 0; data_in = '0;
        f_clear = 0; f_write_enb = 0; f_read = 0; f_data_in = '0;
        repeat (2) tick();
        check_reset_vals("reset");
        reset = 1'b0;

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            data_in = 8'(i);
            write_enb = 1'b1;
            tick();
            sb_q.push_back(8'(i));
            mcount++;
            check_eq("fill_count", count, mcount);
            check_eq("fill_afull", almost_full, (mcount >= 12));
            check_eq("fill_aempty", almost_empty, (mcount <= 4));
            check_eq("fill_full", full, (mcount == 16));
            check_eq("fill_empty", empty, 0);
        end

        // Write while full is rejected
        data_in = 8'hAA;
        tick();
        write_enb = 1'b0;
        check_eq("ovf_pulse", overflow, 1);
        check_eq("ovf_count", count, 16);
        tick();
        check_eq("ovf_clear", overflow, 0);

        // Drain; head must still be 0x00 if the rejected write left memory alone
        read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_v = sb_q.pop_front();
            mcount--;
            check_eq("drain_data", data_out, exp_v);
            check_eq("drain_count", count, mcount);
            check_eq("drain_aempty", almost_empty, (mcount <= 4));
            check_eq("drain_afull", almost_full, (mcount >= 12));
        end
        check_eq("drain_empty", empty, 1);
        tick();
        read = 1'b0;
        check_eq("udf_pulse", underflow, 1);
        check_eq("udf_hold", data_out, 8'h0F);
        check_eq("udf_count", count, 0);
        tick();
        check_eq("udf_clear", underflow, 0);
        check_eq("udf_hold2", data_out, 8'h0F);

        // Preload 5 then stream 20 simultaneous read/write across pointer wrap
        write_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'(8'h40 + i);
            tick();
            sb_q.push_back(8'(8'h40 + i));
        end
        check_eq("pre_count", count, 5);
        read = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data_in = 8'(8'h60 + k);
            tick();
            exp_v = sb_q.pop_front();
            sb_q.push_back(8'(8'h60 + k));
            check_eq("rw_data", data_out, exp_v);
            check_eq("rw_count", count, 5);
            check_eq("rw_ovf", overflow, 0);
            check_eq("rw_udf", underflow, 0);
        end
        read = 1'b0;

        // Top up to full, then read+write together
        for (int i = 0; i < 11; i++) begin
            data_in = 8'(8'h80 + i);
            tick();
            sb_q.push_back(8'(8'h80 + i));
        end
        check_eq("top_full", full, 1);
        data_in = 8'hEE;
        read = 1'b1;
        tick();
        read = 1'b0;
        write_enb = 1'b0;
        exp_v = sb_q.pop_front();
        check_eq("fullrw_data", data_out, exp_v);
        check_eq("fullrw_ovf", overflow, 1);
        check_eq("fullrw_count", count, 15);

        // Reduce to 9, then clear together with a write
        read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_v = sb_q.pop_front();
            check_eq("pre_clr_data", data_out, exp_v);
        end
        read = 1'b0;
        check_eq("pre_clr_count", count, 9);
        clear = 1'b1;
        write_enb = 1'b1;
        data_in = 8'h77;
        tick();
        clear = 1'b0;
        write_enb = 1'b0;
        sb_q.delete();
        check_eq("clr_count", count, 0);
        check_eq("clr_empty", empty, 1);
        check_eq("clr_dout", data_out, 0);
        check_eq("clr_ovf", overflow, 0);
        tick();
        check_eq("clr_still_empty", empty, 1);
        write_enb = 1'b1;
        data_in = 8'h11;
        tick();
        write_enb = 1'b0;
        check_eq("post_clr_count", count, 1);
        read = 1'b1;
        tick();
        read = 1'b0;
        check_eq("post_clr_data", data_out, 8'h11);
        check_eq("post_clr_empty", empty, 1);

        // Fall-through instance
        f_data_in = 8'h5C;
        f_write_enb = 1'b1;
        tick();
        f_write_enb = 1'b0;
        check_eq("fwft_dout", f_data_out, 8'h5C);
        check_eq("fwft_empty", f_empty, 0);
        check_eq("fwft_count", f_count, 1);
        tick();
        check_eq("fwft_dout_hold", f_data_out, 8'h5C);
        f_read = 1'b1;
        tick();
        f_read = 1'b0;
        check_eq("fwft_pop_empty", f_empty, 1);
        check_eq("fwft_pop_dout", f_data_out, 0);
        f_write_enb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_data_in = 8'(8'hA1 + i);
            tick();
            fsb_q.push_back(8'(8'hA1 + i));
        end
        f_write_enb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_v = fsb_q.pop_front();
            check_eq("fwft_head", f_data_out, exp_v);
            f_read = 1'b1;
            tick();
        end
        check_eq("fwft_drain_empty", f_empty, 1);
        tick();
        f_read = 1'b0;
        check_eq("fwft_udf", f_underflow, 1);
        check_eq("fwft_udf_dout", f_data_out, 0);

        // Asynchronous reset between edges with both FIFOs holding data
        write_enb = 1'b1;
        f_write_enb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'(8'h30 + i);
            f_data_in = 8'(8'h50 + i);
            tick();
        end
        write_enb = 1'b0;
        f_write_enb = 1'b0;
        read = 1'b1;
        tick();
        read = 1'b0;
        check_eq("pre_rst_count", count, 2);
        check_eq("pre_rst_dout", data_out, 8'h30);
        check_eq("pre_rst_f_dout", f_data_out, 8'h50);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        tick();
        reset = 1'b0;
        tick();
        check_eq("post_rst_empty", empty, 1);
        check_eq("post_rst_f_empty", f_empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
